// File: rtl/obf_seq_lock.sv
// Key-locked serial pattern detector. A serial KEY_LEN-bit key must be entered
// before the overlapping PATTERN detector runs; wrong keys lead to a sticky black hole.
module obf_seq_lock #(
    parameter int                   KEY_LEN   = 5,
    parameter logic [KEY_LEN-1:0]   KEY       = 5'b11110,
    parameter int                   MAX_TRIES = 0,
    parameter int                   PAT_LEN   = 4,
    parameter logic [PAT_LEN-1:0]   PATTERN   = 4'b1011,
    parameter int                   FAIL_W    = 2
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              x,
    input  logic              x_valid,
    input  logic              relock,
    output logic              out,
    output logic              unlocked,
    output logic              blackhole,
    output logic [FAIL_W-1:0] fail_cnt
);

    localparam int IDX_W  = (KEY_LEN > 1) ? $clog2(KEY_LEN) : 1;
    localparam int FILL_W = $clog2(PAT_LEN + 1);

    typedef enum logic [1:0] {
        S_KEY  = 2'b00,
        S_FUNC = 2'b01,
        S_BH   = 2'b10
    } state_t;

    state_t             state_q, state_d;
    logic [IDX_W-1:0]   idx_q, idx_d;
    logic [FAIL_W-1:0]  fail_q, fail_d;
    logic [PAT_LEN-1:0] sr_q, sr_d;
    logic [FILL_W-1:0]  fill_q, fill_d;
    logic               out_q, out_d;
    logic               unlocked_q, unlocked_d;
    logic               blackhole_q, blackhole_d;

    logic [KEY_LEN-1:0] key_sh;
    logic               key_bit;
    logic [FAIL_W-1:0]  fail_inc;
    logic [PAT_LEN-1:0] sr_next;

    // The expected key bit is the MSB of the key shifted left by the index.
    assign key_sh   = KEY << idx_q;
    assign key_bit  = key_sh[KEY_LEN-1];
    assign fail_inc = (fail_q == {FAIL_W{1'b1}}) ? fail_q : fail_q + FAIL_W'(1);
    assign sr_next  = {sr_q[PAT_LEN-2:0], x};

    always_comb begin
        state_d = state_q;
        idx_d   = idx_q;
        fail_d  = fail_q;
        sr_d    = sr_q;
        fill_d  = fill_q;
        out_d   = 1'b0;
        unique case (state_q)
            S_KEY: begin
                if (x_valid) begin
                    if (x == key_bit) begin
                        if (idx_q == IDX_W'(KEY_LEN - 1)) begin
                            state_d = S_FUNC;
                            idx_d   = '0;
                            sr_d    = '0;
                            fill_d  = '0;
                        end else begin
                            idx_d = idx_q + IDX_W'(1);
                        end
                    end else if (MAX_TRIES == 0) begin
                        state_d = S_BH;
                    end else begin
                        // The wrong bit is consumed; the next attempt starts fresh.
                        fail_d = fail_inc;
                        idx_d  = '0;
                        if (fail_inc == FAIL_W'(MAX_TRIES))
                            state_d = S_BH;
                    end
                end
            end
            S_FUNC: begin
                if (relock) begin
                    state_d = S_KEY;
                    idx_d   = '0;
                    sr_d    = '0;
                    fill_d  = '0;
                end else if (x_valid) begin
                    sr_d   = sr_next;
                    fill_d = (fill_q == FILL_W'(PAT_LEN)) ? fill_q : fill_q + FILL_W'(1);
                    out_d  = (sr_next == PATTERN) && (fill_q >= FILL_W'(PAT_LEN - 1));
                end
            end
            S_BH: begin
                state_d = S_BH;
            end
            default: begin
                state_d = S_BH;
            end
        endcase
        unlocked_d  = (state_d == S_FUNC);
        blackhole_d = (state_d == S_BH);
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= S_KEY;
            idx_q       <= '0;
            fail_q      <= '0;
            sr_q        <= '0;
            fill_q      <= '0;
            out_q       <= 1'b0;
            unlocked_q  <= 1'b0;
            blackhole_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            idx_q       <= idx_d;
            fail_q      <= fail_d;
            sr_q        <= sr_d;
            fill_q      <= fill_d;
            out_q       <= out_d;
            unlocked_q  <= unlocked_d;
            blackhole_q <= blackhole_d;
        end
    end

    assign out       = out_q;
    assign unlocked  = unlocked_q;
    assign blackhole = blackhole_q;
    assign fail_cnt  = fail_q;

endmodule

// File: tb/tb_obf_seq_lock.sv
// Bench for obf_seq_lock: instance 0 uses defaults (MAX_TRIES=0), instance 1 has
// MAX_TRIES=2. Both share stimulus and are checked against a behavioural model.
module tb_obf_seq_lock;

    logic clk = 1'b0;
    logic rst = 1'b0;
    logic x = 1'b0;
    logic x_valid = 1'b0;
    logic relock = 1'b0;
    logic [1:0] d_out, d_unl, d_bh;
    logic [1:0][1:0] d_fc;

    int n_tests = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    obf_seq_lock u0 (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .relock(relock),
        .out(d_out[0]), .unlocked(d_unl[0]), .blackhole(d_bh[0]), .fail_cnt(d_fc[0])
    );

    obf_seq_lock #(.MAX_TRIES(2), .FAIL_W(2)) u1 (
        .clk(clk), .rst(rst), .x(x), .x_valid(x_valid), .relock(relock),
        .out(d_out[1]), .unlocked(d_unl[1]), .blackhole(d_bh[1]), .fail_cnt(d_fc[1])
    );

    // Behavioural model: st 0=locked, 1=functional, 2=black hole.
    // Detector history kept as an integer of the last 4 bits plus a bit count.
    int m_st[2], m_idx[2], m_fail[2], m_nbits[2], m_hist[2], m_out[2];
    int max_tries[2] = '{0, 2};
    int key_val = 30;   // 11110
    int pat_val = 11;   // 1011

    function automatic void model_reset();
        for (int i = 0; i < 2; i++) begin
            m_st[i] = 0; m_idx[i] = 0; m_fail[i] = 0;
            m_nbits[i] = 0; m_hist[i] = 0; m_out[i] = 0;
        end
    endfunction

    function automatic void model_step(input int bx, input int bv, input int br);
        for (int i = 0; i < 2; i++) begin
            m_out[i] = 0;
            if (m_st[i] == 0 && bv != 0) begin
                if (bx == ((key_val >> (4 - m_idx[i])) % 2)) begin
                    if (m_idx[i] == 4) begin
                        m_st[i] = 1; m_idx[i] = 0; m_nbits[i] = 0; m_hist[i] = 0;
                    end else m_idx[i] = m_idx[i] + 1;
                end else if (max_tries[i] == 0) begin
                    m_st[i] = 2;
                end else begin
                    if (m_fail[i] < 3) m_fail[i] = m_fail[i] + 1;
                    m_idx[i] = 0;
                    if (m_fail[i] == max_tries[i]) m_st[i] = 2;
                end
            end else if (m_st[i] == 1) begin
                if (br != 0) begin
                    m_st[i] = 0; m_idx[i] = 0; m_nbits[i] = 0; m_hist[i] = 0;
                end else if (bv != 0) begin
                    m_hist[i] = (m_hist[i] * 2 + bx) % 16;
                    m_nbits[i] = m_nbits[i] + 1;
                    m_out[i] = (m_nbits[i] >= 4 && m_hist[i] == pat_val) ? 1 : 0;
                end
            end
        end
    endfunction

    task automatic step(input logic bx, input logic bv, input logic br);
        @(negedge clk);
        x = bx; x_valid = bv; relock = br;
        @(posedge clk);
        model_step(int'(bx), int'(bv), int'(br));
        #1;
    endtask

    task automatic do_reset();
        @(negedge clk);
        x = 1'b0; x_valid = 1'b0; relock = 1'b0;
        rst = 1'b1;
        model_reset();
        #2 rst = 1'b0;
    endtask

    task automatic send_key();
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
    endtask

    task automatic test_reset();
        do_reset();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if ({d_out[i], d_unl[i], d_bh[i], d_fc[i]} !== 5'b0) begin
                n_fail++;
                $display("FAIL reset inst%0d: got %b want 00000", i,
                         {d_out[i], d_unl[i], d_bh[i], d_fc[i]});
            end
        end
    endtask

    task automatic test_unlock();
        do_reset();
        send_key();
        for (int i = 0; i < 2; i++) begin
            n_tests++;
            if (d_unl[i] !== 1'b1 || d_bh[i] !== 1'b0 || d_fc[i] !== 2'd0) begin
                n_fail++;
                $display("FAIL unlock inst%0d: unl=%b bh=%b fc=%0d want 1 0 0", i,
                         d_unl[i], d_bh[i], d_fc[i]);
            end
        end
    endtask

    task automatic test_blackhole();
        do_reset();
        step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
        n_tests++;
        if (d_bh[0] !== 1'b1 || d_unl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bh_enter: bh=%b unl=%b want 1 0", d_bh[0], d_unl[0]);
        end
        n_tests++;
        if (d_fc[1] !== 2'd1 || d_bh[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL bh_retry_inst1: fc=%0d bh=%b want 1 0", d_fc[1], d_bh[1]);
        end
        for (int c = 0; c < 200; c++) begin
            step(1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
            n_tests++;
            if (d_out[0] !== 1'b0 || d_bh[0] !== 1'b1 || d_unl[0] !== 1'b0) begin
                n_fail++;
                $display("FAIL bh_absorb cyc%0d: out=%b bh=%b unl=%b want 0 1 0", c,
                         d_out[0], d_bh[0], d_unl[0]);
            end
            n_tests++;
            if ({d_out[1], d_unl[1], d_bh[1], d_fc[1]} !==
                {m_out[1] != 0, m_st[1] == 1, m_st[1] == 2, 2'(m_fail[1])}) begin
                n_fail++;
                $display("FAIL bh_rand_inst1 cyc%0d: got %b want %b", c,
                         {d_out[1], d_unl[1], d_bh[1], d_fc[1]},
                         {m_out[1] != 0, m_st[1] == 1, m_st[1] == 2, 2'(m_fail[1])});
            end
        end
        do_reset();
        n_tests++;
        if (d_bh[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL bh_exit_rst: bh=%b want 0", d_bh[0]);
        end
        send_key();
        n_tests++;
        if (d_unl[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL bh_rekey: unl=%b want 1", d_unl[0]);
        end
    endtask

    task automatic test_retry();
        do_reset();
        step(0, 1, 0);
        n_tests++;
        if (d_fc[1] !== 2'd1 || d_bh[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_1: fc=%0d bh=%b want 1 0", d_fc[1], d_bh[1]);
        end
        step(1, 1, 0); step(1, 1, 0); step(0, 1, 0);
        n_tests++;
        if (d_fc[1] !== 2'd2 || d_bh[1] !== 1'b1) begin
            n_fail++;
            $display("FAIL retry_2: fc=%0d bh=%b want 2 1", d_fc[1], d_bh[1]);
        end
        do_reset();
        step(0, 1, 0);
        send_key();
        n_tests++;
        if (d_unl[1] !== 1'b1 || d_fc[1] !== 2'd1 || d_bh[1] !== 1'b0) begin
            n_fail++;
            $display("FAIL retry_unlock: unl=%b fc=%0d bh=%b want 1 1 0",
                     d_unl[1], d_fc[1], d_bh[1]);
        end
    endtask

    task automatic test_pattern();
        logic [6:0] bits;
        int k;
        bits = 7'b1011011;
        for (int g = 0; g < 2; g++) begin
            do_reset();
            send_key();
            k = 0;
            while (k < 7) begin
                if (g == 1 && $urandom_range(0, 1) == 1) begin
                    step(1'($urandom), 0, 0);
                    n_tests++;
                    if (d_out[0] !== 1'b0) begin
                        n_fail++;
                        $display("FAIL pattern_gap bit%0d: out=%b want 0", k, d_out[0]);
                    end
                end else begin
                    step(bits[6 - k], 1, 0);
                    n_tests++;
                    if (d_out[0] !== ((k == 3 || k == 6) ? 1'b1 : 1'b0)) begin
                        n_fail++;
                        $display("FAIL pattern gaps=%0d bit%0d: out=%b want %b", g, k,
                                 d_out[0], (k == 3 || k == 6));
                    end
                    k++;
                end
            end
        end
    endtask

    task automatic test_relock();
        do_reset();
        send_key();
        step(1, 1, 0); step(0, 1, 0); step(1, 1, 0);
        step(1, 1, 1);
        n_tests++;
        if (d_out[0] !== 1'b0 || d_unl[0] !== 1'b0) begin
            n_fail++;
            $display("FAIL relock: out=%b unl=%b want 0 0", d_out[0], d_unl[0]);
        end
        send_key();
        n_tests++;
        if (d_unl[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL relock_rekey: unl=%b want 1", d_unl[0]);
        end
        k_loop: for (int k = 0; k < 4; k++) begin
            step((k == 1) ? 1'b0 : 1'b1, 1, 0);
            n_tests++;
            if (d_out[0] !== ((k == 3) ? 1'b1 : 1'b0)) begin
                n_fail++;
                $display("FAIL relock_clear bit%0d: out=%b want %b", k, d_out[0], (k == 3));
            end
        end
    endtask

    task automatic test_async_reset();
        do_reset();
        send_key();
        #2 rst = 1'b1;
        model_reset();
        #1;
        n_tests++;
        if (d_unl !== 2'b00 || d_out !== 2'b00 || d_bh !== 2'b00) begin
            n_fail++;
            $display("FAIL async_rst_func: unl=%b out=%b bh=%b want 00", d_unl, d_out, d_bh);
        end
        rst = 1'b0;
        step(1, 1, 0); step(1, 1, 0); step(1, 1, 0);
        #2 rst = 1'b1;
        model_reset();
        #1 rst = 1'b0;
        step(1, 1, 0); step(0, 1, 0);
        n_tests++;
        if (d_unl[0] !== 1'b0 || d_bh[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst_midkey: unl=%b bh=%b want 0 1", d_unl[0], d_bh[0]);
        end
        do_reset();
        send_key();
        n_tests++;
        if (d_unl[0] !== 1'b1) begin
            n_fail++;
            $display("FAIL async_rst_rekey: unl=%b want 1", d_unl[0]);
        end
    endtask

    task automatic test_random();
        do_reset();
        for (int c = 0; c < 600; c++) begin
            if (m_st[0] == 0 && $urandom_range(0, 3) != 0) begin
                // Mostly steer toward the key so the functional path gets exercised.
                step(1'((key_val >> (4 - m_idx[0])) % 2), 1, 0);
            end else begin
                step(1'($urandom), 1'($urandom_range(0, 3) != 0),
                     1'($urandom_range(0, 40) == 0));
            end
            if (m_st[0] == 2) do_reset();
            for (int i = 0; i < 2; i++) begin
                n_tests++;
                if ({d_out[i], d_unl[i], d_bh[i], d_fc[i]} !==
                    {m_out[i] != 0, m_st[i] == 1, m_st[i] == 2, 2'(m_fail[i])}) begin
                    n_fail++;
                    $display("FAIL random inst%0d cyc%0d: got %b want %b", i, c,
                             {d_out[i], d_unl[i], d_bh[i], d_fc[i]},
                             {m_out[i] != 0, m_st[i] == 1, m_st[i] == 2, 2'(m_fail[i])});
                end
            end
        end
    endtask

    initial begin
        model_reset();
        test_reset();
        test_unlock();
        test_blackhole();
        test_retry();
        test_pattern();
        test_relock();
        test_async_reset();
        test_random();
        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule

// File: doc/obf_seq_lock.md
Name: obf_seq_lock

Overview:
- Parametrised obfuscation wrapper around a serial sequence detector on a 1-bit input stream.
- After reset the block sits in a key-entry phase and must receive a KEY_LEN-bit serial key before the functional detector runs.
- Wrong key bits either send the block to a black-hole state at once, or count as failed attempts up to a bounded retry limit.
- Adds input valid qualification, a relock command and status outputs.

Parameters:
- KEY_LEN, 5: number of serial key bits.
- KEY, 5'b11110: unlock key; bits are consumed MSB first (KEY[KEY_LEN-1] is the first bit).
- MAX_TRIES, 0: failed attempts allowed before the black hole. 0 means the first wrong bit enters the black hole.
- PAT_LEN, 4: length of the functional detection pattern, minimum 2.
- PATTERN, 4'b1011: the pattern detected, MSB is the oldest bit; overlapping matches count.
- FAIL_W, 2: width of fail_cnt; must hold MAX_TRIES, minimum 1.

Ports:
- clk  input  1  system clock, rising edge.
- rst  input  1  asynchronous, active-high reset.
- x  input  1  serial data or key bit.
- x_valid  input  1  x is sampled only on edges where x_valid=1.
- relock  input  1  synchronous command to return from FUNC to key entry.
- out  output  1  registered one-cycle pulse on pattern match.
- unlocked  output  1  high while in FUNC.
- blackhole  output  1  high while in the black-hole state.
- fail_cnt  output  FAIL_W  number of failed key attempts since reset, saturating.

Behaviour:
- Reset (async, rst=1):
  - state=KEY, key index=0, fail counter=0, detector shift register=0, detector fill count=0.
  - out=0, unlocked=0, blackhole=0, fail_cnt=0.
  - Reset asserted at any point, including mid-key, in FUNC or in BLACKHOLE, returns to these values immediately.
- States: KEY, FUNC, BLACKHOLE. The state is encoded so that no illegal encoding is reachable. Any illegal encoding decodes to BLACKHOLE.
- Edges with x_valid=0 leave state, key index, shift register and fill count unchanged, and drive out=0.
- KEY state, on an edge with x_valid=1:
  - If x==KEY[KEY_LEN-1-idx] and idx<KEY_LEN-1: idx+1.
  - If x matches and idx==KEY_LEN-1: go to FUNC, idx=0, shift register and fill count cleared. unlocked goes high from the next cycle.
  - If x does not match and MAX_TRIES==0: go to BLACKHOLE.
  - If x does not match and MAX_TRIES>0: fail counter+1 and idx=0; the wrong bit is consumed and not reused as the first bit of a new attempt. If the incremented count equals MAX_TRIES, go to BLACKHOLE.
  - out is 0 throughout KEY.
- FUNC state, on an edge with x_valid=1:
  - shift register <= {sr[PAT_LEN-2:0], x}.
  - fill count increments, saturating at PAT_LEN.
  - out <= 1 iff {sr[PAT_LEN-2:0], x}==PATTERN and fill count+1 >= PAT_LEN. Otherwise out <= 0.
  - Latency: out is high in the cycle after the edge that samples the final pattern bit.
- relock=1 in FUNC:
  - Go to KEY with idx=0 and clear the detector; out=0.
  - relock takes priority over a simultaneous x_valid, and that x is dropped.
  - fail_cnt is not cleared.
  - relock is ignored in KEY and in BLACKHOLE.
- BLACKHOLE: absorbing state.
  - All inputs are ignored. out=0, unlocked=0, blackhole=1.
  - Exit only through rst.
- Status outputs: unlocked and blackhole are registered decodes of state. fail_cnt mirrors the fail counter.
- Stable x while x_valid=1 across consecutive edges is consumed as consecutive bits.

Test Plan:
- Defaults. Reset, then send key 1,1,1,1,0 with x_valid=1. unlocked=1 on the cycle after the 5th edge; blackhole=0; fail_cnt=0.
- Defaults, MAX_TRIES=0. After reset send 1,1,0. blackhole=1 after the 3rd edge. Then 200 random x/x_valid/relock cycles give out=0 and blackhole=1 throughout. Pulsing rst gives blackhole=0, state KEY.
- MAX_TRIES=2, FAIL_W=2:
  - Send 0: fail_cnt=1.
  - Send 1,1,0: fail_cnt=2 and blackhole=1.
  - Repeat with 0 then the correct key 11110: unlocked=1 and fail_cnt=1.
- Unlocked, default pattern. Stream 1,0,1,1,0,1,1 gives out pulses one cycle after the 4th and the 7th bits (overlap). Inserting x_valid=0 gaps between bits gives the same pulses, delayed, with out=0 in the gap cycles.
- Unlocked after sending 1,0,1, assert relock together with x_valid=1, x=1. No out pulse; unlocked=0 next cycle. Re-entering the key then streaming 1,0,1,1 gives exactly one pulse (detector was cleared).
- Reset mid-operation: rst asserted asynchronously between edges after 3 correct key bits. Outputs go to 0 immediately. The full 5-bit key is then required again.
